// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the load/store unit (op codes, FSM states,
// byte-strobe width).
package mem_pkg;

   localparam int STRB_W = 4;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LH  = 3'd1,
      OP_LW  = 3'd2,
      OP_LBU = 3'd3,
      OP_LHU = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational alignment helper. Flags misaligned accesses,
// builds byte strobes and replicated store data, and right-justifies and
// masks load data (zero-extended; sign extension happens downstream).
module mem_align
   import mem_pkg::*;
(
   input  op_e               op,
   input  logic [1:0]        addr_lo,
   input  logic [31:0]       wdata,
   input  logic [31:0]       rdata,
   output logic              misalign,
   output logic [STRB_W-1:0] we,
   output logic [31:0]       wdata_rep,
   output logic [31:0]       rdata_al
);

   logic [31:0] sh;

   assign sh = rdata >> {addr_lo, 3'b000};

   // Per-op decode of alignment, strobes, store replication and load mask
   always_comb begin
      misalign  = 1'b0;
      we        = '0;
      wdata_rep = '0;
      rdata_al  = '0;
      case (op)
         OP_LB, OP_LBU: rdata_al = {24'h0, sh[7:0]};
         OP_LH, OP_LHU: begin
            misalign = addr_lo[0];
            rdata_al = {16'h0, sh[15:0]};
         end
         OP_LW: begin
            misalign = |addr_lo;
            rdata_al = sh;
         end
         OP_SB: begin
            we        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         OP_SH: begin
            misalign  = addr_lo[0];
            we        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         OP_SW: begin
            misalign  = |addr_lo;
            we        = 4'b1111;
            wdata_rep = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between EX and a word-wide
// DRAM port. IDLE -> ACCESS -> RESP; misaligned ops skip straight to RESP.
// Optional ack timeout is built when MEM_TIMEOUT_EN is defined.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 255
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              dram_en,
   output logic [STRB_W-1:0] dram_we,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [31:0]       dram_wdata,
   input  logic [31:0]       dram_rdata,
   input  logic              dram_ack,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misalign,
   output logic              resp_err,
   output logic              stall
);

   state_e              state, state_nxt;
   op_e                 op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                mis_q;
   logic                tmo_hit;

   op_e                 al_op;
   logic [1:0]          al_lo;
   logic                al_mis;
   logic [STRB_W-1:0]   al_we;
   logic [31:0]         al_wdata;
   logic [31:0]         al_rdata;

   // In IDLE the decoder looks at the incoming request (misalign check);
   // afterwards it works on the latched op.
   assign al_op = (state == ST_IDLE) ? op_e'(req_op) : op_q;
   assign al_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];

   mem_align u_align (
      .op        (al_op),
      .addr_lo   (al_lo),
      .wdata     (wdata_q),
      .rdata     (dram_rdata),
      .misalign  (al_mis),
      .we        (al_we),
      .wdata_rep (al_wdata),
      .rdata_al  (al_rdata)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TMO_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign tmo_hit = (state == ST_ACCESS) && !dram_ack &&
                    (tmo_cnt == CNT_W'(TMO_CYC - 1));

   // Count cycles spent waiting for ack; restarts on every new ACCESS
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst || state != ST_ACCESS) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Error flag for an aborted access, cleared on the next accept
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst)                                err_q <= 1'b0;
      else if (state == ST_IDLE && req_valid)     err_q <= 1'b0;
      else if (tmo_hit)                           err_q <= 1'b1;
   end

   assign resp_err = resp_valid & err_q;
`else
   logic unused_tmo;
   assign unused_tmo = TMO_CYC[0];
   assign tmo_hit    = 1'b0;
   assign resp_err   = 1'b0;
`endif

   // State register
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_valid) state_nxt = al_mis ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (dram_ack || tmo_hit) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Request latch and response data capture
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         op_q       <= OP_LB;
         addr_q     <= '0;
         wdata_q    <= '0;
         mis_q      <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               op_q       <= op_e'(req_op);
               addr_q     <= req_addr;
               wdata_q    <= req_wdata;
               mis_q      <= al_mis;
               resp_rdata <= '0;
            end
            ST_ACCESS: if (dram_ack) resp_rdata <= al_rdata;
            default: ;
         endcase
      end
   end

   assign req_ready     = (state == ST_IDLE);
   assign stall         = req_valid & ~req_ready;
   assign resp_valid    = (state == ST_RESP);
   assign resp_misalign = resp_valid & mis_q;

   // DRAM port is quiet outside ACCESS, so reset drops it immediately
   assign dram_en    = (state == ST_ACCESS);
   assign dram_we    = dram_en ? al_we : '0;
   assign dram_addr  = dram_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign dram_wdata = dram_en ? al_wdata : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table, randomized ops against an arithmetic
// reference model, plus hand sequences for reset-in-ACCESS, stall and
// (with MEM_TIMEOUT_EN) the ack timeout.
module tb_mem_lsu;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        dram_en;
   logic [3:0]  dram_we;
   logic [31:0] dram_addr;
   logic [31:0] dram_wdata;
   logic [31:0] dram_rdata = '0;
   logic        dram_ack = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic        resp_err;
   logic        stall;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(4)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .dram_en(dram_en), .dram_we(dram_we), .dram_addr(dram_addr),
      .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_ack(dram_ack),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misalign(resp_misalign), .resp_err(resp_err), .stall(stall)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
      logic        exp_mis;
      logic [31:0] exp_rd;
      logic [3:0]  exp_we;
      logic [31:0] exp_wd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: access size, alignment and lane placement from plain arithmetic
   function automatic vec_t model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
      vec_t v;
      int size, off;
      longint mask;
      bit store;
      size  = (op == 0 || op == 3 || op == 5) ? 1 : (op == 1 || op == 4 || op == 6) ? 2 : 4;
      store = (op >= 5);
      off   = int'(addr % 4);
      mask  = (64'd1 << (8 * size)) - 1;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
      v.exp_mis = ((addr % size) != 0);
      v.exp_rd = 0; v.exp_we = 0; v.exp_wd = 0;
      if (!v.exp_mis) begin
         if (store) begin
            v.exp_we = 4'(((1 << size) - 1) << off);
            if (size == 1)      v.exp_wd = (wdata % 256) * 32'h01010101;
            else if (size == 2) v.exp_wd = (wdata % 65536) * 32'h00010001;
            else                v.exp_wd = wdata;
         end else begin
            v.exp_rd = 32'((longint'(rdata) >> (8 * off)) & mask);
         end
      end
      return v;
   endfunction

   // Issue one op, serve it with an ack after v.dly ACCESS cycles, check result
   task automatic run_op(input vec_t v, input string tag);
      @(negedge cpu_clk);
      chk({tag, " ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
      @(negedge cpu_clk);
      req_valid = 1'b0;
      if (!v.exp_mis) begin
         for (int k = 0; k <= v.dly; k++) begin
            chk({tag, " dram_en"}, dram_en, 1'b1);
            chk({tag, " early_resp"}, resp_valid, 1'b0);
            if (k == 0) begin
               chk({tag, " dram_addr"}, dram_addr, v.addr & 32'hFFFF_FFFC);
               chk({tag, " dram_we"}, dram_we, v.exp_we);
               chk({tag, " dram_wdata"}, dram_wdata, v.exp_wd);
            end
            if (k == v.dly) begin
               dram_ack = 1'b1; dram_rdata = v.rdata;
            end else begin
               dram_rdata = $urandom;
            end
            @(negedge cpu_clk);
            dram_ack = 1'b0;
         end
      end
      chk({tag, " resp_valid"}, resp_valid, 1'b1);
      chk({tag, " resp_rdata"}, resp_rdata, v.exp_rd);
      chk({tag, " resp_misalign"}, resp_misalign, v.exp_mis);
      chk({tag, " resp_err"}, resp_err, 1'b0);
      chk({tag, " en_in_resp"}, dram_en, 1'b0);
      @(negedge cpu_clk);
      chk({tag, " resp_once"}, resp_valid, 1'b0);
      chk({tag, " ready_after"}, req_ready, 1'b1);
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
      tbl[1] = '{3'd0, 32'h103, 32'h0,        32'h80AABBCC, 0, 1'b0, 32'h00000080, 4'b0000, 32'h0};
      tbl[2] = '{3'd4, 32'h102, 32'h0,        32'h80AABBCC, 1, 1'b0, 32'h000080AA, 4'b0000, 32'h0};
      tbl[3] = '{3'd5, 32'h201, 32'h12,       32'h0,        0, 1'b0, 32'h0,        4'b0010, 32'h12121212};
      tbl[4] = '{3'd2, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
      tbl[5] = '{3'd6, 32'h206, 32'hABCD1234, 32'h0,        2, 1'b0, 32'h0,        4'b1100, 32'h12341234};
      tbl[6] = '{3'd1, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
      tbl[7] = '{3'd7, 32'h300, 32'hCAFEF00D, 32'h0,        3, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D};
      tbl[8] = '{3'd3, 32'h000, 32'h0,        32'h11223344, 0, 1'b0, 32'h00000044, 4'b0000, 32'h0};

      // Reset state
      repeat (2) @(negedge cpu_clk);
      chk("rst dram_en", dram_en, 1'b0);
      chk("rst dram_we", dram_we, 4'b0);
      chk("rst dram_addr", dram_addr, 32'h0);
      chk("rst dram_wdata", dram_wdata, 32'h0);
      chk("rst resp_valid", resp_valid, 1'b0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_misalign", resp_misalign, 1'b0);
      chk("rst resp_err", resp_err, 1'b0);
      cpu_rst = 1'b0;
      @(negedge cpu_clk);
      chk("rst req_ready", req_ready, 1'b1);

      // Directed vectors
      for (int i = 0; i < 9; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         vec_t r;
         r = model(3'($urandom_range(0, 7)), $urandom & 32'h0000_FFFF, $urandom, $urandom,
                   $urandom_range(0, 3));
         run_op(r, $sformatf("rnd%0d", i));
      end

      // Ack while IDLE is ignored
      @(negedge cpu_clk);
      dram_ack = 1'b1;
      @(negedge cpu_clk);
      chk("idle_ack resp_valid", resp_valid, 1'b0);
      chk("idle_ack ready", req_ready, 1'b1);
      dram_ack = 1'b0;

      // Reset during the 3rd ACCESS cycle of an SW, late ack ignored
      req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h400; req_wdata = 32'h55AA55AA;
      @(negedge cpu_clk);
      req_valid = 1'b0;
      chk("rstacc en1", dram_en, 1'b1);
      @(negedge cpu_clk);
      chk("rstacc en2", dram_en, 1'b1);
      @(negedge cpu_clk);
      chk("rstacc en3", dram_en, 1'b1);
      cpu_rst = 1'b1;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      chk("rstacc en_dropped", dram_en, 1'b0);
      chk("rstacc dram_we", dram_we, 4'b0);
      chk("rstacc resp_valid", resp_valid, 1'b0);
      chk("rstacc ready", req_ready, 1'b1);
      @(negedge cpu_clk);
      dram_ack = 1'b1;
      @(negedge cpu_clk);
      dram_ack = 1'b0;
      chk("rstacc late_ack resp", resp_valid, 1'b0);
      chk("rstacc late_ack ready", req_ready, 1'b1);
      @(negedge cpu_clk);
      chk("rstacc quiet", resp_valid, 1'b0);

      // Back-to-back: req_valid held, stall until IDLE
      req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h500;
      chk("b2b stall_idle", stall, 1'b0);
      @(negedge cpu_clk);
      chk("b2b stall_acc0", stall, 1'b1);
      @(negedge cpu_clk);
      chk("b2b stall_acc1", stall, 1'b1);
      dram_ack = 1'b1; dram_rdata = 32'h01020304;
      @(negedge cpu_clk);
      dram_ack = 1'b0;
      chk("b2b stall_resp", stall, 1'b1);
      chk("b2b resp1", resp_rdata, 32'h01020304);
      @(negedge cpu_clk);
      chk("b2b stall_idle2", stall, 1'b0);
      req_addr = 32'h504;
      @(negedge cpu_clk);
      req_valid = 1'b0;
      chk("b2b second_acc", dram_addr, 32'h504);
      dram_ack = 1'b1; dram_rdata = 32'hA5A5A5A5;
      @(negedge cpu_clk);
      dram_ack = 1'b0;
      chk("b2b resp2", resp_rdata, 32'hA5A5A5A5);
      @(negedge cpu_clk);

`ifdef MEM_TIMEOUT_EN
      // Timeout after 4 ACCESS cycles without ack
      req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h600;
      for (int k = 0; k < 4; k++) begin
         @(negedge cpu_clk);
         chk("tmo dram_en", dram_en, 1'b1);
         chk("tmo stall", stall, 1'b1);
      end
      @(negedge cpu_clk);
      chk("tmo resp_valid", resp_valid, 1'b1);
      chk("tmo resp_err", resp_err, 1'b1);
      chk("tmo resp_rdata", resp_rdata, 32'h0);
      chk("tmo stall_resp", stall, 1'b1);
      @(negedge cpu_clk);
      chk("tmo stall_idle", stall, 1'b0);
      chk("tmo err_cleared", resp_err, 1'b0);
      req_valid = 1'b0;
      @(negedge cpu_clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
